// File: rtl/mul_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_sequencer                                                   |
// | Purpose  : Iterative 32x32 unsigned multiplier controller. It borrows the  |
// |            core's 32-bit ALU for a fixed 32-step shift-add sequence and    |
// |            returns the low (MUL) or high (MULHU) word of the product.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mul_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             op_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic             kill_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             alu_req_o,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   output logic [2:0]       alu_control_o,
   input  logic [WIDTH-1:0] alu_result_i,
   input  logic [3:0]       alu_flags_i
);

   // Sequencer states
   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   // Index of the final shift-add step and the ALU opcode for ADD
   localparam logic [4:0] c_CNT_LAST = 5'd31;
   localparam logic [2:0] c_ALU_ADD  = 3'b000;

   // Position of the carry-out inside the ALU flag vector {v, c, n, z}
   localparam int c_FLAG_C = 2;

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0] hi_q,     hi_d;
   logic [WIDTH-1:0] lo_q,     lo_d;
   logic [4:0]       cnt_q,    cnt_d;
   logic             op_q,     op_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             w_carry;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_hi_step;
   logic [WIDTH-1:0] w_lo_step;

   // Overflow, negative and zero flags carry no information for an
   // unsigned shift-add; they are gathered here only to mark them as unused.
   logic w_unused_flags;
   assign w_unused_flags = ^{alu_flags_i[3], alu_flags_i[1:0]};

   // One shift-add step: add the multiplicand when the current multiplier bit
   // is set, then shift the 65-bit {carry, sum, lo} right by one position.
   always_comb begin
      w_carry   = 1'b0;
      w_sum     = hi_q;
      if (lo_q[0]) begin
         w_carry = alu_flags_i[c_FLAG_C];
         w_sum   = alu_result_i;
      end
      w_hi_step = {w_carry, w_sum[WIDTH-1:1]};
      w_lo_step = {w_sum[0], lo_q[WIDTH-1:1]};
   end

   // Next-state and datapath register update logic
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      result_d = result_q;

      case (state_q)
         c_IDLE: begin
            // A simultaneous kill suppresses acceptance of a new request
            if (start_i && !kill_i) begin
               mcand_d = op_a_i;
               lo_d    = op_b_i;
               hi_d    = '0;
               cnt_d   = '0;
               op_d    = op_i;
               state_d = c_RUN;
            end
         end

         c_RUN: begin
            if (kill_i) begin
               // Abort: the partial product is discarded, result is untouched
               state_d = c_IDLE;
            end else begin
               hi_d  = w_hi_step;
               lo_d  = w_lo_step;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == c_CNT_LAST) begin
                  // Capture the selected word from the final step's outputs so
                  // it is already valid while done is high.
                  result_d = op_q ? w_hi_step : w_lo_step;
                  state_d  = c_DONE;
               end
            end
         end

         c_DONE: begin
            state_d = c_IDLE;
         end

         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= c_IDLE;
         mcand_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         op_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         result_q <= result_d;
      end
   end

   assign busy_o        = (state_q != c_IDLE);
   assign done_o        = (state_q == c_DONE);
   assign alu_req_o     = (state_q == c_RUN);
   assign result_o      = result_q;
   assign alu_a_o       = hi_q;
   assign alu_b_o       = mcand_q;
   assign alu_control_o = c_ALU_ADD;

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mul_sequencer                                                |
// | Purpose  : Self-checking bench for mul_sequencer with a behavioural ALU    |
// |            and a plain-arithmetic product model.                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mul_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic        op_i;
   logic [31:0] op_a_i;
   logic [31:0] op_b_i;
   logic        kill_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic        alu_req_o;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic [2:0]  alu_control_o;
   logic [31:0] alu_result_i;
   logic [3:0]  alu_flags_i;

   int total = 0;
   int bad   = 0;

   // Per-operation observations filled in by run_op
   int          lat;
   int          req_cnt;
   int          ctrl_bad;
   int          busy_bad;
   logic [31:0] res;

   mul_sequencer #(.WIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .op_i          (op_i),
      .op_a_i        (op_a_i),
      .op_b_i        (op_b_i),
      .kill_i        (kill_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .result_o      (result_o),
      .alu_req_o     (alu_req_o),
      .alu_a_o       (alu_a_o),
      .alu_b_o       (alu_b_o),
      .alu_control_o (alu_control_o),
      .alu_result_i  (alu_result_i),
      .alu_flags_i   (alu_flags_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of the core's combinational ALU (ADD only)
   logic [32:0] alu_full;
   assign alu_full     = {1'b0, alu_a_o} + {1'b0, alu_b_o};
   assign alu_result_i = alu_full[31:0];
   assign alu_flags_i  = {(alu_a_o[31] == alu_b_o[31]) && (alu_full[31] != alu_a_o[31]),
                          alu_full[32], alu_full[31], (alu_full[31:0] == 32'd0)};

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic o);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      return o ? p[63:32] : p[31:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},   busy_o,        0);
      chk({tag, "_done"},   done_o,        0);
      chk({tag, "_req"},    alu_req_o,     0);
      chk({tag, "_result"}, result_o,      0);
      chk({tag, "_alu_a"},  alu_a_o,       0);
      chk({tag, "_alu_b"},  alu_b_o,       0);
      chk({tag, "_ctrl"},   alu_control_o, 0);
   endtask

   // Issue one request and watch up to 40 cycles. Cycle k is E+k where E is
   // the edge that samples the request. p1/p2 pulse a stray start, kill_at
   // pulses kill, rst_at pulls rst_n low for one edge (0 disables each).
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                         input int p1, input int p2, input int kill_at, input int rst_at);
      lat = 0; req_cnt = 0; ctrl_bad = 0; busy_bad = 0; res = 'x;
      @(negedge clk);
      start_i = 1'b1; op_i = o; op_a_i = a; op_b_i = b;
      @(negedge clk);
      start_i = 1'b0; op_a_i = $urandom; op_b_i = $urandom; op_i = ~o;
      for (int k = 1; k <= 40; k++) begin
         if (k > 1) @(negedge clk);
         start_i = (k == p1) || (k == p2);
         if (start_i) begin
            op_a_i = $urandom; op_b_i = $urandom; op_i = ~o;
         end
         kill_i = (k == kill_at);
         if (k == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk_reset_outputs("midrst");
         end
         if (rst_at != 0 && k == rst_at + 1) rst_n = 1'b1;
         if (kill_at != 0 && k == kill_at + 1) chk("kill_busy_fall", busy_o, 0);
         if (k == 1) begin
            chk("first_alu_a", alu_a_o, 0);
            chk("first_alu_b", alu_b_o, a);
         end
         if (kill_at == 0 && rst_at == 0 && busy_o !== 1'b1) busy_bad++;
         if (alu_control_o !== 3'b000) ctrl_bad++;
         if (done_o) begin
            lat = k;
            res = result_o;
            break;
         end
         if (alu_req_o) req_cnt++;
      end
      kill_i = 1'b0;
      if (start_i) begin
         @(posedge clk);
         #1 start_i = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] a, b, prev;
      logic        o;

      rst_n = 1'b0; start_i = 1'b0; op_i = 1'b0; op_a_i = '0; op_b_i = '0; kill_i = 1'b0;
      #12;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // 3 x 5, low word, with latency and handshake checks
      run_op(32'd3, 32'd5, 1'b0, 0, 0, 0, 0);
      chk("lat_3x5", lat, 33);
      chk("res_3x5_lo", res, 32'h0000000F);
      chk("req_cycles_3x5", req_cnt, 32);
      chk("ctrl_3x5", ctrl_bad, 0);
      chk("busy_3x5", busy_bad, 0);
      @(negedge clk);
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
      chk("idle_result_hold", result_o, 32'h0000000F);

      run_op(32'd3, 32'd5, 1'b1, 0, 0, 0, 0);
      chk("res_3x5_hi", res, 32'h00000000);

      // Carry into hi on every step
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 0, 0, 0);
      chk("res_ff_lo", res, 32'h00000001);
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 0, 0, 0);
      chk("res_ff_hi", res, 32'hFFFFFFFE);
      chk("lat_ff", lat, 33);

      run_op(32'h80000000, 32'd2, 1'b1, 0, 0, 0, 0);
      chk("res_msb_hi", res, 32'h00000001);
      chk("req_cycles_msb", req_cnt, 32);
      chk("ctrl_msb", ctrl_bad, 0);
      run_op(32'h80000000, 32'd2, 1'b0, 0, 0, 0, 0);
      chk("res_msb_lo", res, 32'h00000000);

      // Stray starts during RUN and during DONE are ignored
      run_op(32'd7, 32'd9, 1'b0, 5, 33, 0, 0);
      chk("lat_7x9_stray", lat, 33);
      chk("res_7x9_stray", res, 32'h0000003F);
      chk("busy_7x9_stray", busy_bad, 0);
      // Earliest legal restart lands in cycle E+34
      run_op(32'd11, 32'd13, 1'b0, 0, 0, 0, 0);
      chk("lat_b2b", lat, 33);
      chk("res_b2b", res, 32'd143);

      // Kill mid-operation: no done, result keeps the last value
      prev = result_o;
      run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 0, 0, 10, 0);
      chk("kill_no_done", lat, 0);
      chk("kill_result_hold", result_o, prev);
      run_op(32'd6, 32'd7, 1'b0, 0, 0, 0, 0);
      chk("res_6x7", res, 32'h0000002A);

      // Asynchronous reset mid-operation, then a clean operation
      run_op(32'hDEADBEEF, 32'h01234567, 1'b1, 0, 0, 0, 20);
      chk("rst_no_done", lat, 0);
      chk("rst_result", result_o, 0);
      run_op(32'h00010000, 32'h00010000, 1'b1, 0, 0, 0, 0);
      chk("res_after_rst", res, 32'h00000001);

      // Randomized operands against the arithmetic model
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         b = $urandom;
         o = 1'($urandom_range(0, 1));
         if (i % 4 == 1) a = 32'd0;
         if (i % 4 == 2) b = b | 32'h80000001;
         run_op(a, b, o, 0, 0, 0, 0);
         chk($sformatf("rand%0d_res", i), res, model(a, b, o));
         chk($sformatf("rand%0d_lat", i), lat, 33);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
